mig_app_master: RTL and testbench

- Initiator side of the DDR4 MIG user (app) interface.
- Accepts single-beat read/write requests on a valid/ready request port and drives app_addr/app_cmd/app_en plus the write-data FIFO signals (app_wdf_*).
- Tracks outstanding reads and returns read data on an unstalled response port.
- Sits between user logic and the MIG core, or the MIG simulation model in the sim top.

---
 rtl/mig_app_master_if.sv | 56 +++++
 rtl/mig_app_master.sv | 138 +++++++++++++
 tb/tb_mig_app_master.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mig_app_master_if.sv
// Bundles for the mig_app_master request/response port and the MIG app command/data port.
// In each bundle, "master" is the side that issues commands.
interface mig_req_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 512,
  parameter int MASK_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [MASK_WIDTH-1:0] req_wbe;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_wbe,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_wbe,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

interface mig_app_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 512,
  parameter int MASK_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic                  app_hi_pri;
  logic                  app_rdy;
  logic [DATA_WIDTH-1:0] app_wdf_data;
  logic [MASK_WIDTH-1:0] app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_wdf_end;
  logic                  app_wdf_rdy;
  logic [DATA_WIDTH-1:0] app_rd_data;
  logic                  app_rd_data_valid;
  logic                  app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en, app_hi_pri, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
  modport slave (
    input  app_addr, app_cmd, app_en, app_hi_pri, app_wdf_data, app_wdf_mask,
           app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mig_app_master.sv
// Single-beat read/write initiator for the DDR4 MIG app interface; counts reads in
// flight and forwards read data one cycle later on an unstalled response port.
module mig_app_master #(
  parameter int ADDR_WIDTH      = 28,
  parameter int DATA_WIDTH      = 512,
  parameter int MASK_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 calib_done,
  mig_req_if.slave             req,
  mig_app_if.master            app,
  output logic [CNT_WIDTH-1:0] rd_outstanding,
  output logic                 err_unexp_rd
);

  typedef enum logic [1:0] {S_CALIB, S_IDLE, S_WR, S_RD} state_e;

  state_e                state_q, state_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  data_done_q, data_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic       req_ready_c, app_en_c, wren_c, rd_inc;
  logic [2:0] app_cmd_c;
  logic       unused_rd_end;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d     = state_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    req_ready_c = 1'b0;
    app_en_c    = 1'b0;
    app_cmd_c   = 3'b000;
    wren_c      = 1'b0;
    unique case (state_q)
      S_CALIB: if (calib_done) state_d = S_IDLE;
      S_IDLE: begin
        if (!calib_done) begin
          state_d = S_CALIB;
        end else begin
          req_ready_c = req.req_wr || (cnt_q < CNT_WIDTH'(MAX_OUTSTANDING));
          if (req.req_valid && req_ready_c) begin
            addr_d      = req.req_addr;
            wdata_d     = req.req_wdata;
            mask_d      = ~req.req_wbe;
            cmd_done_d  = 1'b0;
            data_done_d = 1'b0;
            state_d     = req.req_wr ? S_WR : S_RD;
          end
        end
      end
      S_WR: begin
        // Command and data handshakes complete independently; leave once both have.
        app_en_c = !cmd_done_q;
        wren_c   = !data_done_q;
        if (app_en_c && app.app_rdy)   cmd_done_d  = 1'b1;
        if (wren_c && app.app_wdf_rdy) data_done_d = 1'b1;
        if (cmd_done_d && data_done_d) state_d = calib_done ? S_IDLE : S_CALIB;
      end
      S_RD: begin
        app_en_c  = 1'b1;
        app_cmd_c = 3'b001;
        if (app.app_rdy) state_d = calib_done ? S_IDLE : S_CALIB;
      end
      default: state_d = S_CALIB;
    endcase
  end

  assign rd_inc = (state_q == S_RD) && app.app_rdy;

  // A read issued in the same cycle as a return leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | (app.app_rd_data_valid && (cnt_q == '0));
    if (rd_inc && !app.app_rd_data_valid) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (!rd_inc && app.app_rd_data_valid && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CALIB;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      // NOTE: datapath registers are reset too, so the app bus reads all-zero out of reset.
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_valid_q <= app.app_rd_data_valid;
      if (app.app_rd_data_valid) rsp_data_q <= app.app_rd_data;
    end
  end

  assign req.req_ready    = req_ready_c;
  assign req.rsp_valid    = rsp_valid_q;
  assign req.rsp_data     = rsp_data_q;
  assign app.app_addr     = addr_q;
  assign app.app_cmd      = app_cmd_c;
  assign app.app_en       = app_en_c;
  assign app.app_hi_pri   = 1'b0;
  assign app.app_wdf_data = wdata_q;
  assign app.app_wdf_mask = mask_q;
  assign app.app_wdf_wren = wren_c;
  assign app.app_wdf_end  = wren_c;
  assign rd_outstanding   = cnt_q;
  assign err_unexp_rd     = err_q;
  assign unused_rd_end    = app.app_rd_data_end;

endmodule

// File: tb/tb_mig_app_master.sv
// Randomised scoreboard bench for mig_app_master: a byte-level memory reference model
// predicts commands, write beats and read responses; a MIG model answers the app port.
module tb_mig_app_master;
  localparam int AW = 28, DW = 512, MW = 64, MAXO = 16, CW = 5;

  typedef logic [DW-1:0] data_t;
  typedef logic [AW-1:0] addr_t;
  typedef struct packed { logic wr; addr_t addr; } cmd_t;
  typedef struct packed { data_t d; logic [MW-1:0] m; } wd_t;

  logic          clk = 1'b0, rst_n = 1'b0, calib_done = 1'b0;
  logic [CW-1:0] rd_outstanding;
  logic          err_unexp_rd;

  mig_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) rq ();
  mig_app_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) ap ();

  mig_app_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                   .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .req(rq), .app(ap),
    .rd_outstanding(rd_outstanding), .err_unexp_rd(err_unexp_rd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: memory contents and predicted traffic, in request order.
  data_t ref_mem [addr_t];
  cmd_t  cmd_exp_q [$];
  wd_t   wd_exp_q [$];
  data_t rsp_exp_q [$];

  // MIG model state.
  data_t mig_mem [addr_t];
  addr_t wa_q [$];
  wd_t   wdat_q [$];
  data_t ret_q [$];
  int    ref_out = 0;
  int    rdy_pct = 100, wdf_pct = 100, ret_pct = 0;
  bit    force_ret = 1'b0, inject = 1'b0;
  data_t last_ret;
  int    en_cyc, wr_cyc;
  bit    acc;

  task automatic check(input string name, input data_t act, input data_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic data_t rand_data();
    data_t r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic data_t merge(input data_t old_d, input data_t new_d, input logic [MW-1:0] en);
    data_t r = old_d;
    for (int i = 0; i < MW; i++) if (en[i]) r[i*8 +: 8] = new_d[i*8 +: 8];
    return r;
  endfunction

  function automatic data_t ref_read(input addr_t a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic data_t mig_read(input addr_t a);
    return mig_mem.exists(a) ? mig_mem[a] : '0;
  endfunction

  task automatic mig_drive();
    ap.app_rdy     = ($urandom_range(99) < rdy_pct);
    ap.app_wdf_rdy = ($urandom_range(99) < wdf_pct);
    if (inject) begin
      ap.app_rd_data_valid = 1'b1;
      ap.app_rd_data       = rand_data();
      rsp_exp_q.push_back(ap.app_rd_data);
    end else if (ret_q.size() > 0 && (force_ret || $urandom_range(99) < ret_pct)) begin
      ap.app_rd_data_valid = 1'b1;
      ap.app_rd_data       = ret_q.pop_front();
    end else begin
      ap.app_rd_data_valid = 1'b0;
      ap.app_rd_data       = rand_data();
    end
    ap.app_rd_data_end = ap.app_rd_data_valid;
    if (ap.app_rd_data_valid) last_ret = ap.app_rd_data;
  endtask

  // Evaluated on settled signals just before the edge: what fires at that edge.
  task automatic observe();
    cmd_t  c;
    wd_t   w;
    addr_t a;
    bit    rd_inc;
    acc    = 1'b0;
    rd_inc = 1'b0;
    if (rq.req_valid && rq.req_ready) begin
      acc = 1'b1;
      cmd_exp_q.push_back('{wr: rq.req_wr, addr: rq.req_addr});
      if (rq.req_wr) begin
        wd_exp_q.push_back('{d: rq.req_wdata, m: ~rq.req_wbe});
        ref_mem[rq.req_addr] = merge(ref_read(rq.req_addr), rq.req_wdata, rq.req_wbe);
      end else begin
        rsp_exp_q.push_back(ref_read(rq.req_addr));
      end
    end
    if (ap.app_en) en_cyc++;
    if (ap.app_wdf_wren) wr_cyc++;
    check1("app_wdf_end", ap.app_wdf_end, ap.app_wdf_wren);
    check1("app_hi_pri", ap.app_hi_pri, 1'b0);
    if (ap.app_en && ap.app_rdy) begin
      if (cmd_exp_q.size() == 0) begin
        check1("cmd_unexpected", 1'b1, 1'b0);
      end else begin
        c = cmd_exp_q.pop_front();
        check("app_cmd", DW'(ap.app_cmd), DW'(c.wr ? 3'b000 : 3'b001));
        check("app_addr", DW'(ap.app_addr), DW'(c.addr));
        if (c.wr) wa_q.push_back(ap.app_addr);
        else begin
          ret_q.push_back(mig_read(ap.app_addr));
          rd_inc = 1'b1;
        end
      end
    end
    if (ap.app_wdf_wren && ap.app_wdf_rdy) begin
      if (wd_exp_q.size() == 0) begin
        check1("wdf_unexpected", 1'b1, 1'b0);
      end else begin
        w = wd_exp_q.pop_front();
        check("app_wdf_data", ap.app_wdf_data, w.d);
        check("app_wdf_mask", DW'(ap.app_wdf_mask), DW'(w.m));
        wdat_q.push_back('{d: ap.app_wdf_data, m: ap.app_wdf_mask});
      end
    end
    if (wa_q.size() > 0 && wdat_q.size() > 0) begin
      a = wa_q.pop_front();
      w = wdat_q.pop_front();
      mig_mem[a] = merge(mig_read(a), w.d, ~w.m);
    end
    if (rd_inc && !ap.app_rd_data_valid) ref_out++;
    else if (!rd_inc && ap.app_rd_data_valid && ref_out > 0) ref_out--;
  endtask

  task automatic tick();
    mig_drive();
    #1;
    observe();
    @(posedge clk);
    #1;
    check("rd_outstanding", DW'(rd_outstanding), DW'(ref_out));
  endtask

  task automatic do_req(input logic wr, input addr_t addr, input data_t d, input logic [MW-1:0] be);
    bit ok = 1'b0;
    rq.req_valid = 1'b1;
    rq.req_wr    = wr;
    rq.req_addr  = addr;
    rq.req_wdata = d;
    rq.req_wbe   = be;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = acc;
    end
    rq.req_valid = 1'b0;
    if (!ok) check1("req_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      idle = !ap.app_en && !ap.app_wdf_wren && cmd_exp_q.size() == 0 && wd_exp_q.size() == 0;
      if (!idle) tick();
    end
    if (!idle) check1("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    ret_pct = 50;
    for (int i = 0; i < 2000 && !done; i++) begin
      done = ref_out == 0 && ret_q.size() == 0 && rsp_exp_q.size() == 0 && !rq.rsp_valid;
      if (!done) tick();
    end
    if (!done) check1("drain_timeout", 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && rq.rsp_valid) begin
      if (rsp_exp_q.size() == 0) check1("rsp_unexpected", 1'b1, 1'b0);
      else check("rsp_data", rq.rsp_data, rsp_exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    data_t pat;
    rq.req_valid = 1'b0; rq.req_wr = 1'b0; rq.req_addr = '0; rq.req_wdata = '0; rq.req_wbe = '0;
    ap.app_rdy = 1'b0; ap.app_wdf_rdy = 1'b0; ap.app_rd_data = '0;
    ap.app_rd_data_valid = 1'b0; ap.app_rd_data_end = 1'b0;
    #1;
    check1("rst_req_ready", rq.req_ready, 1'b0);
    check1("rst_app_en", ap.app_en, 1'b0);
    check1("rst_wren", ap.app_wdf_wren, 1'b0);
    check1("rst_rsp_valid", rq.rsp_valid, 1'b0);
    check1("rst_err", err_unexp_rd, 1'b0);
    check("rst_cnt", DW'(rd_outstanding), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Calibration gating with a read held pending.
    rq.req_valid = 1'b1; rq.req_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check1("calib_req_ready", rq.req_ready, 1'b0);
      check1("calib_app_en", ap.app_en, 1'b0);
      check1("calib_wren", ap.app_wdf_wren, 1'b0);
    end
    calib_done = 1'b1;
    #1 check1("calib_rise_ready", rq.req_ready, 1'b0);
    tick();
    check1("calib_done_ready", rq.req_ready, 1'b1);
    rq.req_valid = 1'b0;

    // Masked write then readback.
    pat = rand_data();
    en_cyc = 0; wr_cyc = 0;
    do_req(1'b1, AW'('h10), pat, 64'h0000_0000_0000_00FF);
    check1("wr_app_en", ap.app_en, 1'b1);
    check("wr_app_cmd", DW'(ap.app_cmd), '0);
    check1("wr_wren", ap.app_wdf_wren, 1'b1);
    check1("wr_end", ap.app_wdf_end, 1'b1);
    check("wr_mask", DW'(ap.app_wdf_mask), DW'(64'hFFFF_FFFF_FFFF_FF00));
    wait_idle();
    check("wr_en_cycles", DW'(en_cyc), DW'(1));
    check("wr_wren_cycles", DW'(wr_cyc), DW'(1));
    ret_pct = 100;
    do_req(1'b0, AW'('h10), '0, '0);
    wait_idle();
    drain();

    // Data FIFO stalls for three cycles.
    wdf_pct = 0; en_cyc = 0; wr_cyc = 0;
    do_req(1'b1, AW'('h20), rand_data(), {$urandom, $urandom});
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("stall_app_en", ap.app_en, 1'b0);
      check1("stall_wren", ap.app_wdf_wren, 1'b1);
      check1("stall_req_ready", rq.req_ready, 1'b0);
    end
    wdf_pct = 100;
    wait_idle();
    check("stall_en_cycles", DW'(en_cyc), DW'(1));
    check("stall_wren_cycles", DW'(wr_cyc), DW'(4));
    check1("stall_done_ready", rq.req_ready, 1'b1);

    // Fill to the outstanding limit.
    ret_pct = 0;
    for (int i = 0; i < MAXO; i++) begin
      do_req(1'b0, AW'($urandom_range(7) * 8), '0, '0);
      wait_idle();
    end
    check("full_cnt", DW'(rd_outstanding), DW'(MAXO));
    rq.req_wr = 1'b0; rq.req_valid = 1'b1;
    #1 check1("full_rd_ready", rq.req_ready, 1'b0);
    rq.req_wr = 1'b1;
    #1 check1("full_wr_ready", rq.req_ready, 1'b1);
    rq.req_valid = 1'b0; rq.req_wr = 1'b0;
    force_ret = 1'b1;
    tick();
    force_ret = 1'b0;
    check("one_ret_cnt", DW'(rd_outstanding), DW'(MAXO - 1));
    rq.req_valid = 1'b1;
    #1 check1("one_ret_rd_ready", rq.req_ready, 1'b1);
    rq.req_valid = 1'b0;
    drain();

    // Read issue coinciding with a return.
    ret_pct = 0;
    for (int i = 0; i < 2; i++) begin
      do_req(1'b0, AW'($urandom_range(7) * 8), '0, '0);
      wait_idle();
    end
    do_req(1'b0, AW'('h10), '0, '0);
    force_ret = 1'b1;
    tick();
    force_ret = 1'b0;
    check("same_cycle_cnt", DW'(rd_outstanding), DW'(2));
    check1("same_cycle_rsp_valid", rq.rsp_valid, 1'b1);
    check("same_cycle_rsp_data", rq.rsp_data, last_ret);
    pat = last_ret;
    tick();
    check1("rsp_valid_drop", rq.rsp_valid, 1'b0);
    check("rsp_data_hold", rq.rsp_data, pat);
    drain();

    // Unexpected read data.
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check1("unexp_err", err_unexp_rd, 1'b1);
    check("unexp_cnt", DW'(rd_outstanding), '0);
    for (int i = 0; i < 3; i++) tick();
    check1("unexp_err_sticky", err_unexp_rd, 1'b1);

    // Reset in the middle of a write.
    wdf_pct = 0;
    do_req(1'b1, AW'('h30), rand_data(), '1);
    tick();
    rst_n = 1'b0;
    #1;
    check1("midrst_app_en", ap.app_en, 1'b0);
    check1("midrst_wren", ap.app_wdf_wren, 1'b0);
    check1("midrst_req_ready", rq.req_ready, 1'b0);
    check1("midrst_err", err_unexp_rd, 1'b0);
    check1("midrst_rsp_valid", rq.rsp_valid, 1'b0);
    check("midrst_cnt", DW'(rd_outstanding), '0);
    check("midrst_addr", DW'(ap.app_addr), '0);
    check("midrst_mask", DW'(ap.app_wdf_mask), '0);
    cmd_exp_q.delete(); wd_exp_q.delete(); rsp_exp_q.delete();
    wa_q.delete(); wdat_q.delete(); ret_q.delete();
    ref_mem.delete(); mig_mem.delete();
    ref_out = 0;
    wdf_pct = 100;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Randomised traffic with back-pressure and calibration drops.
    rdy_pct = 70; wdf_pct = 70; ret_pct = 40;
    for (int i = 0; i < 150; i++) begin
      do_req(1'($urandom_range(1)), AW'($urandom_range(7) * 8), rand_data(), {$urandom, $urandom});
      if (i % 50 == 25) begin
        calib_done = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        calib_done = 1'b1;
      end
    end
    rdy_pct = 100; wdf_pct = 100;
    wait_idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
